axis_pkt_gen: RTL and testbench



---
 rtl/axis_gen_pkg.sv | 20 ++
 rtl/axis_pattern_gen.sv | 57 +++++
 rtl/axis_pkt_gen.sv | 152 +++++++++++++++
 tb/tb_axis_pkt_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_pkg.sv
// ---------------------------------------------------------------------------
// axis_gen_pkg
// Shared definitions for the AXI4-Stream packet generator:
//   state_t   - controller FSM states (IDLE, SEND, GAP, FIN)
//   CNT_W     - width of the beat and packet counters
//   LFSR_TAPS - tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
// ---------------------------------------------------------------------------
package axis_gen_pkg;

  localparam int         CNT_W     = 8;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/axis_pattern_gen.sv
// ---------------------------------------------------------------------------
// axis_pattern_gen
// Beat data pattern register. Holds the current tdata value and moves to the
// next value whenever i_advance is high at a rising clock edge.
//
// Build option (macro AXIS_PKT_GEN_LFSR_EN):
//   undefined - value increments by one (mod 2^DATA_W)
//   defined   - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with
//               the feedback bit entering at bit 0; needs DATA_W==8, SEED!=0
//
// Ports:
//   aclk       in   clock, rising edge
//   aresetn    in   asynchronous active-low reset (pattern returns to SEED)
//   i_advance  in   step the pattern (one beat was transferred)
//   o_data     out  current pattern value
// ---------------------------------------------------------------------------
module axis_pattern_gen
  import axis_gen_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_advance,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_next;

`ifdef AXIS_PKT_GEN_LFSR_EN
  // An all-zero LFSR state locks up, and the tap set only covers 8 bits.
  generate
    if (DATA_W != 8 || SEED == '0) begin : g_bad_cfg
      $error("axis_pattern_gen: LFSR mode needs DATA_W==8 and SEED!=0");
    end
  endgenerate

  logic w_fb;
  assign w_fb   = ^(r_data & DATA_W'(LFSR_TAPS));
  assign w_next = {r_data[DATA_W-2:0], w_fb};
`else
  assign w_next = r_data + DATA_W'(1);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_data <= SEED;
    end else if (i_advance) begin
      r_data <= w_next;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/axis_pkt_gen.sv
// ---------------------------------------------------------------------------
// axis_pkt_gen
// AXI4-Stream packet source. A start pulse in IDLE launches a run of
// pkt_count packets, each pkt_len beats long (0 treated as 1), with tlast on
// each packet's final beat and GAP_CYCLES idle cycles between packets.
// tvalid is decoded purely from the FSM state, so it never depends on tready,
// and tdata/tlast only change on a handshake or state change.
//
// Build option: AXIS_PKT_GEN_LFSR_EN selects an LFSR data pattern instead of
// the incrementing one (see axis_pattern_gen).
//
// Ports:
//   aclk           in   clock, rising edge
//   aresetn        in   asynchronous active-low reset
//   start          in   run command, sampled only in IDLE
//   pkt_len        in   beats per packet, latched on start
//   pkt_count      in   packets per run, latched on start (0 = empty run)
//   busy           out  run in progress (SEND or GAP)
//   done           out  one-cycle end-of-run pulse
//   m_axis_tdata   out  beat data
//   m_axis_tvalid  out  beat valid
//   m_axis_tlast   out  final beat of packet
//   m_axis_tready  in   downstream ready
// ---------------------------------------------------------------------------
module axis_pkt_gen
  import axis_gen_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                GAP_CYCLES = 2,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(8'h01)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [7:0]        pkt_len,
  input  logic [7:0]        pkt_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  // Last value of the gap counter before returning to SEND.
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [15:0]      r_gap_cnt;

  logic w_hs;
  logic w_last_beat;
  logic w_last_pkt;

  assign m_axis_tvalid = (r_state == SEND);
  assign w_hs          = m_axis_tvalid & m_axis_tready;
  // r_len is never 0 while in SEND, so len-1 cannot wrap.
  assign w_last_beat   = (r_beat_cnt == r_len - CNT_W'(1));
  assign w_last_pkt    = (r_pkt_cnt == r_count - CNT_W'(1));
  assign m_axis_tlast  = m_axis_tvalid & w_last_beat;
  assign busy          = (r_state == SEND) || (r_state == GAP);
  assign done          = (r_state == FIN);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (pkt_count == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        if (w_hs && w_last_beat) begin
          if (w_last_pkt) begin
            w_state_nxt = FIN;
          end else if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = SEND;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = SEND;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_len      <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len      <= (pkt_len == '0) ? CNT_W'(1) : pkt_len;
            r_count    <= pkt_count;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_pkt_cnt  <= r_pkt_cnt + CNT_W'(1);
              r_gap_cnt  <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  axis_pattern_gen #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_advance (w_hs),
    .o_data    (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_pkt_gen.sv
module tb_axis_pkt_gen;

  localparam int         DATA_W = 8;
  localparam logic [7:0] SEED   = 8'h01;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       tready = 1'b0;
  logic [7:0] pkt_len = '0;
  logic [7:0] pkt_count = '0;

  logic       start_a, start_b;
  logic       busy_a, done_a, tvalid_a, tlast_a;
  logic       busy_b, done_b, tvalid_b, tlast_b;
  logic [7:0] tdata_a, tdata_b;

  logic       busy, done, tvalid, tlast;
  logic [7:0] tdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_pat [2];
  int pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign busy    = sel ? busy_b   : busy_a;
  assign done    = sel ? done_b   : done_a;
  assign tvalid  = sel ? tvalid_b : tvalid_a;
  assign tlast   = sel ? tlast_b  : tlast_a;
  assign tdata   = sel ? tdata_b  : tdata_a;

  // Instance A: default 2-cycle inter-packet gap. Instance B: back-to-back.
  axis_pkt_gen #(.DATA_W(DATA_W), .GAP_CYCLES(2), .SEED(SEED)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .start(start_a), .pkt_len(pkt_len),
    .pkt_count(pkt_count), .busy(busy_a), .done(done_a),
    .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tlast(tlast_a),
    .m_axis_tready(tready)
  );

  axis_pkt_gen #(.DATA_W(DATA_W), .GAP_CYCLES(0), .SEED(SEED)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .start(start_b), .pkt_len(pkt_len),
    .pkt_count(pkt_count), .busy(busy_b), .done(done_b),
    .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tlast(tlast_b),
    .m_axis_tready(tready)
  );

  always #5 aclk = ~aclk;

  // Reference data sequence: value following v after one transferred beat.
  function automatic logic [7:0] next_pat(input logic [7:0] v);
`ifdef AXIS_PKT_GEN_LFSR_EN
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
`else
    return v + 8'd1;
`endif
  endfunction

  // One complete run on instance s, called at a falling edge.
  // mode 0: tready=1, 1: random tready, 2: fixed tready table.
  task automatic run(input int s, input int len, input int cnt, input int mode, input bit repulse);
    int  L, total, idx, gap_left, gap, cyc, budget;
    bit  exp_last;
    L      = (len == 0) ? 1 : len;
    total  = L * cnt;
    gap    = (s == 1) ? 0 : 2;
    budget = 8 * total + 4 * cnt + 100;
    sel       = s[0];
    pkt_len   = len[7:0];
    pkt_count = cnt[7:0];
    start     = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    if (cnt == 0) begin
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL empty_tvalid: got %b want 0", tvalid); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b want 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b want 0", busy); end
      @(negedge aclk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse: got %b want 0", done); end
      return;
    end
    idx = 0; gap_left = 0; cyc = 0;
    while (idx < total && cyc < budget) begin
      if (repulse && cyc == 2) begin
        start = 1'b1; pkt_len = 8'd9; pkt_count = 8'd7;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       tready = 1'b1;
        1:       tready = ($urandom_range(0, 1) == 1);
        default: tready = (pat[cyc % 7] != 0);
      endcase
      if (gap_left > 0) begin
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL gap_tvalid: got %b want 0 (beat %0d)", tvalid, idx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1", busy); end
        gap_left--;
      end else begin
        exp_last = ((idx % L) == L - 1);
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL send_tvalid: got %b want 1 (beat %0d)", tvalid, idx); end
        checks++; if (tdata !== exp_pat[s]) begin errors++; $display("FAIL send_tdata: got %h want %h (beat %0d)", tdata, exp_pat[s], idx); end
        checks++; if (tlast !== exp_last) begin errors++; $display("FAIL send_tlast: got %b want %b (beat %0d)", tlast, exp_last, idx); end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL send_busy_done: got %b/%b want 1/0", busy, done); end
        if (tready) begin
          exp_pat[s] = next_pat(exp_pat[s]);
          idx++;
          if (exp_last && idx < total) gap_left = gap;
        end
      end
      @(negedge aclk);
      cyc++;
    end
    start = 1'b0;
    if (idx < total) begin
      errors++; $display("FAIL run_timeout: got %0d beats want %0d", idx, total);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL end_busy: got %b want 0", busy); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL end_tvalid: got %b want 0", tvalid); end
    @(negedge aclk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL end_done_pulse: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_reset();
    checks++; if (tvalid_a !== 1'b0 || tvalid_b !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b%b want 00", tvalid_a, tvalid_b); end
    checks++; if (tlast_a !== 1'b0 || tlast_b !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b%b want 00", tlast_a, tlast_b); end
    checks++; if (tdata_a !== SEED || tdata_b !== SEED) begin errors++; $display("FAIL reset_tdata: got %h/%h want %h", tdata_a, tdata_b, SEED); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done: got %b%b%b%b want 0000", busy_a, done_a, busy_b, done_b);
    end
    aresetn = 1'b1;
    exp_pat[0] = SEED;
    exp_pat[1] = SEED;
    @(negedge aclk);
  endtask

  task automatic test_single();       run(0, 4, 1, 0, 0); endtask
  task automatic test_gap();          run(0, 3, 2, 0, 0); endtask
  task automatic test_backpressure(); run(0, 4, 1, 2, 0); endtask
  task automatic test_empty();        run(0, 4, 0, 0, 0); endtask
  task automatic test_back_to_back(); run(1, 0, 3, 0, 0); endtask
  task automatic test_repulse();      run(0, 4, 2, 0, 1); endtask

  task automatic test_max();
    run(1, 255, 2, 0, 0);
    run(1, 2, 255, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 3), 1, 0);
    end
  endtask

  task automatic test_reset_midrun();
    sel = 1'b0; pkt_len = 8'd5; pkt_count = 8'd2; tready = 1'b1; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    checks++; if (tvalid_a !== 1'b0) begin errors++; $display("FAIL midreset_tvalid: got %b want 0", tvalid_a); end
    checks++; if (tdata_a !== SEED) begin errors++; $display("FAIL midreset_tdata: got %h want %h", tdata_a, SEED); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
    @(negedge aclk);
    aresetn = 1'b1;
    exp_pat[0] = SEED;
    exp_pat[1] = SEED;
    @(negedge aclk);
    run(0, 3, 1, 0, 0);
  endtask

  initial begin
    exp_pat[0] = SEED;
    exp_pat[1] = SEED;
    repeat (2) @(negedge aclk);
    test_reset();
    test_single();
    test_gap();
    test_backpressure();
    test_empty();
    test_back_to_back();
    test_repulse();
    test_random();
    test_max();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
